// File: rtl/reg_write_arbiter.sv
// Four-requester round-robin arbiter guarding a single shared register.
// A grant lasts one cycle. The write lands only if the winner is still requesting when that cycle ends.
module reg_write_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            req,
    input  logic [4*DATA_W-1:0]   data_in,
    output logic [3:0]            gnt,
    output logic [3:0]            ack,
    output logic [DATA_W-1:0]     reg_q,
    output logic                  busy,
    output logic [7:0]            wr_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [1:0]          winner_q, winner_d;
    logic [3:0]          gnt_q, gnt_d;
    logic [3:0]          ack_q, ack_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [1:0]          pick_s;

    // First set request bit, searching upward from p and wrapping modulo 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic       found;
        rr_pick = p;
        found   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = p + k[1:0];
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end else begin
                found   = found;
            end
        end
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] i);
        onehot4 = 4'b0001 << i;
    endfunction

    // Next-state and output decode for the two-state grant FSM.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        winner_d = winner_q;
        gnt_d    = 4'b0000;
        ack_d    = 4'b0000;
        data_d   = data_q;
        cnt_d    = cnt_q;
        pick_s   = rr_pick(req, ptr_q);
        case (state_q)
            IDLE: begin
                if (req != 4'b0000) begin
                    winner_d = pick_s;
                    gnt_d    = onehot4(pick_s);
                    ptr_d    = pick_s + 2'd1;
                    state_d  = GRANT;
                end else begin
                    state_d  = IDLE;
                end
            end
            GRANT: begin
                // Data is sampled on the exit edge, not at request time.
                if (req[winner_q]) begin
                    data_d = data_in[winner_q*DATA_W +: DATA_W];
                    ack_d  = onehot4(winner_q);
                    cnt_d  = cnt_q + 8'd1;
                end else begin
                    data_d = data_q;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= 2'd0;
            winner_q <= 2'd0;
            gnt_q    <= 4'b0000;
            ack_q    <= 4'b0000;
            data_q   <= '0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            winner_q <= winner_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
        end
    end

    assign gnt      = gnt_q;
    assign ack      = ack_q;
    assign reg_q    = data_q;
    assign busy     = (state_q == GRANT);
    assign wr_count = cnt_q;

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter DATA_W SHALL be: DATA_W, default 8, width of the shared register and of each requester's data word.
REQ-002 Port clk SHALL be: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port reset SHALL be: reset  input  1  synchronous, active-high reset.
REQ-004 Port req SHALL be: req  input  4  request lines; bit i = requester i.
REQ-005 Port data_in SHALL be: data_in  input  4*DATA_W  packed write data; requester i at bits [i*DATA_W +: DATA_W].
REQ-006 Port gnt SHALL be: gnt  output  4  registered one-hot grant, or all-zero.
REQ-007 Port ack SHALL be: ack  output  4  registered one-cycle write-done pulse, one-hot or all-zero.
REQ-008 Port reg_q SHALL be: reg_q  output  DATA_W  shared register contents.
REQ-009 Port busy SHALL be: busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 Port wr_count SHALL be: wr_count  output  8  count of completed writes, modulo 256.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-012 IDLE, req == 0: SHALL stay in IDLE with gnt = 0.
REQ-013 IDLE, req != 0: SHALL pick one winner by round-robin, load gnt with its one-hot code and enter GRANT at the same edge, so gnt is visible one cycle after req is first sampled.
REQ-014 Round-robin: priority SHALL start at index ptr and ascend modulo 4; the first set req bit wins.
REQ-015 ptr SHALL become (winner+1) mod 4 at the edge that enters GRANT, whether or not the grant later completes.
REQ-016 GRANT, req[winner] still 1: at the next edge reg_q SHALL load data_in[winner], ack[winner] SHALL pulse for one cycle, wr_count SHALL increment, gnt SHALL clear and the FSM SHALL return to IDLE.
REQ-017 GRANT, req[winner] dropped to 0 (abort): at the next edge reg_q, ack and wr_count SHALL be unchanged, gnt SHALL clear and the FSM SHALL return to IDLE.
REQ-018 Data written SHALL be data_in sampled on the GRANT-exit edge, not the data present at request time.
REQ-019 Changes to req bits other than the winner's during GRANT SHALL be ignored.
REQ-020 Minimum period per write SHALL be 2 cycles (IDLE, then GRANT); the ack cycle is an IDLE cycle.
REQ-021 Any req still high in the ack cycle, including the just-acked requester's, SHALL be treated as a new request and arbitrated with the updated ptr.
REQ-022 wr_count SHALL wrap from 255 to 0 with no flag.
REQ-023 gnt and ack SHALL never have more than one bit set.
REQ-024 ack SHALL never be asserted in the same cycle as gnt.

Reset
REQ-025 With reset high at a rising edge, at that edge: state = IDLE, ptr = 0, gnt = 0, ack = 0, reg_q = 0, wr_count = 0, busy = 0.
REQ-026 Reset SHALL override all other activity, including a GRANT in progress; no write or ack SHALL result from an interrupted grant.
REQ-027 Reset SHALL be sampled only on clk rising edges; mid-cycle reset pulses SHALL have no effect.

Verification
REQ-028 Scenario single: after reset, req = 0001, data_in[0] = 8'hA5 held -> gnt = 0001 at cycle+1, ack = 0001 and reg_q = A5 at cycle+2, wr_count = 1.
REQ-029 Scenario fairness: req = 1111 held continuously, each requester dropping its bit only in its own ack cycle and re-raising it one cycle later -> grant order 0,1,2,3,0, one write every 2 cycles.
REQ-030 Scenario abort: req = 0100, gnt = 0100 observed, req dropped to 0000 during GRANT -> no ack, reg_q unchanged, wr_count unchanged; next request from 1000 is granted before a request from 0000+0100 (ptr = 3).
REQ-031 Scenario late data: data_in[1] = 11 at request time, changed to 22 during GRANT -> reg_q = 22.
REQ-032 Scenario reset mid-grant: reset asserted in the GRANT cycle -> next cycle all outputs zero, no ack; with req = 1010 held, the next grant goes to requester 1.
REQ-033 Scenario wrap: 256 completed writes -> wr_count returns to 0; gnt and ack stay one-hot throughout, checked by assertion.
